// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button/switch input conditioner: channel state
// encodings and the counter-width helper used by every debounce counter.
package button_conditioner_pkg;

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  // Counters only ever reach their terminal value, so this is all the width they need.
  function automatic int cnt_width(input int terminal);
    return (terminal < 1) ? 1 : $clog2(terminal) + 1;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One push-button channel: 2-FF synchroniser, debounce FSM, press strobe and
// optional auto-repeat strobe train while held.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 12500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int RTERM = (REPEAT_DELAY > 0) ?
                         ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY - 1 : REPEAT_RATE - 1) : 0;
  localparam int RW = cnt_width(RTERM);

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LAST  = RW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  logic          meta;
  logic          sync;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt;
  logic          repeating;   // first repeat already fired; now timing by REPEAT_RATE

  // NOTE: non-blocking assignments throughout, so every stage samples the value
  // its predecessor held before this edge; blocking here would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      repeating <= 1'b0;
      level     <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= IDLE;
          end else if (cnt == DB_LAST) begin
            state     <= PRESSED;
            level     <= 1'b1;
            pulse     <= 1'b1;
            rcnt      <= '0;
            repeating <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (REPEAT_DELAY > 0) begin
            if ((!repeating && rcnt == DELAY_LAST) || (repeating && rcnt == RATE_LAST)) begin
              pulse     <= 1'b1;
              rcnt      <= '0;
              repeating <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed resumes the repeat schedule where it paused.
          if (sync) begin
            state <= PRESSED;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Input front end: debounced button levels/strobes per channel plus a
// glitch-free switch vector with a change strobe.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 12500000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  input  logic [SW_WIDTH-1:0]    switches_raw,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_pulse,
  output logic [SW_WIDTH-1:0]    switches_stable,
  output logic                   switches_changed
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_channel (
      .clock(clock),
      .reset(reset),
      .raw  (button_raw[g]),
      .level(button_level[g]),
      .pulse(button_pulse[g])
    );
  end

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [SW_WIDTH-1:0] sw_prev;
  logic [CW-1:0]       sw_cnt;

  // One counter for the whole vector: any bit moving restarts qualification.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta          <= '0;
      sw_sync          <= '0;
      sw_prev          <= '0;
      sw_cnt           <= '0;
      switches_stable  <= '0;
      switches_changed <= 1'b0;
    end else begin
      sw_meta          <= switches_raw;
      sw_sync          <= sw_meta;
      sw_prev          <= sw_sync;
      switches_changed <= 1'b0;
      if (sw_sync != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt != DB_LAST) begin
        sw_cnt <= sw_cnt + 1'b1;
      end else if (sw_sync != switches_stable) begin
        switches_stable  <= sw_sync;
        switches_changed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: press, bounce, glitch, auto-repeat,
// switch filtering and reset mid-press, with hand-computed cycle numbers.
module tb_button_conditioner;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] button_raw,      rep_button_raw;
  logic [7:0] switches_raw,    rep_switches_raw;
  logic [1:0] button_level,    rep_button_level;
  logic [1:0] button_pulse,    rep_button_pulse;
  logic [7:0] switches_stable, rep_switches_stable;
  logic       switches_changed, rep_switches_changed;

  int cyc;
  int n_assert;
  int n_fail;

  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_BUTTONS(2), .SW_WIDTH(8), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_RATE(3)
  ) dut (
    .clock(clock), .reset(reset),
    .button_raw(button_raw), .switches_raw(switches_raw),
    .button_level(button_level), .button_pulse(button_pulse),
    .switches_stable(switches_stable), .switches_changed(switches_changed)
  );

  button_conditioner #(
    .NUM_BUTTONS(2), .SW_WIDTH(8), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut_rep (
    .clock(clock), .reset(reset),
    .button_raw(rep_button_raw), .switches_raw(rep_switches_raw),
    .button_level(rep_button_level), .button_pulse(rep_button_pulse),
    .switches_stable(rep_switches_stable), .switches_changed(rep_switches_changed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one edge and settle; outputs read here are the values for cycle 'cyc'.
  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},       {30'd0, button_level},     32'd0);
    chk({tag, "_pulse"},       {30'd0, button_pulse},     32'd0);
    chk({tag, "_sw_stable"},   {24'd0, switches_stable},  32'd0);
    chk({tag, "_sw_changed"},  {31'd0, switches_changed}, 32'd0);
    chk({tag, "_rep_level"},   {30'd0, rep_button_level}, 32'd0);
    chk({tag, "_rep_pulse"},   {30'd0, rep_button_pulse}, 32'd0);
  endtask

  // After release, the first edge is cycle 1; raw driven before the tick for
  // cycle c is first sampled at edge c.
  task automatic do_reset();
    button_raw       = '0;
    rep_button_raw   = '0;
    switches_raw     = '0;
    rep_switches_raw = '0;
    reset            = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    logic [3:0] bounce;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;

    // 1: clean press on button 0 from edge 10 -> pulse only in cycle 16.
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      button_raw[0] = (c >= 10);
      tick();
      chk("clean_pulse0", {31'd0, button_pulse[0]}, {31'd0, c == 16});
      chk("clean_level0", {31'd0, button_level[0]}, {31'd0, c >= 16});
      chk("clean_pulse1", {31'd0, button_pulse[1]}, 32'd0);
    end

    // 2+3: button 0 bounces 1,0,1,0 at edges 10-13 then holds from 14 -> pulse at 20;
    // button 1 high for edges 10-12 only -> nothing.
    do_reset();
    bounce = 4'b0101;
    for (int c = 1; c <= 28; c++) begin
      button_raw[0] = (c >= 14) ? 1'b1 : ((c >= 10) ? bounce[c-10] : 1'b0);
      button_raw[1] = (c >= 10 && c <= 12);
      tick();
      chk("bounce_pulse0", {31'd0, button_pulse[0]}, {31'd0, c == 20});
      chk("bounce_level0", {31'd0, button_level[0]}, {31'd0, c >= 20});
      chk("glitch_pulse1", {31'd0, button_pulse[1]}, 32'd0);
      chk("glitch_level1", {31'd0, button_level[1]}, 32'd0);
    end

    // 4: auto-repeat, held edges 10-49 -> pulses 16, 26, 29, ..., 50; level low at 56.
    do_reset();
    for (int c = 1; c <= 62; c++) begin
      rep_button_raw[0] = (c >= 10 && c <= 49);
      tick();
      chk("repeat_pulse0", {31'd0, rep_button_pulse[0]},
          {31'd0, (c == 16) || (c >= 26 && c <= 50 && (c - 26) % 3 == 0)});
      chk("repeat_level0", {31'd0, rep_button_level[0]}, {31'd0, c >= 16 && c <= 55});
    end

    // 5: switches 00->A5 at edge 5, one-cycle FF glitch at edge 20.
    do_reset();
    for (int c = 1; c <= 35; c++) begin
      switches_raw = (c == 20) ? 8'hFF : ((c >= 5) ? 8'hA5 : 8'h00);
      tick();
      chk("sw_changed", {31'd0, switches_changed}, {31'd0, c == 11});
      chk("sw_stable", {24'd0, switches_stable}, (c >= 11) ? 32'hA5 : 32'h00);
    end

    // 6: button 1 pressed (level 1 from cycle 7), button 0 mid-debounce when reset hits.
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      button_raw[0] = (c >= 10);
      button_raw[1] = 1'b1;
      tick();
      chk("prereset_pulse1", {31'd0, button_pulse[1]}, {31'd0, c == 7});
      chk("prereset_level1", {31'd0, button_level[1]}, {31'd0, c >= 7});
      chk("prereset_pulse0", {31'd0, button_pulse[0]}, 32'd0);
    end
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick();
    chk_all_zero("midreset_hold");
    reset = 1'b0;
    cyc   = 0;
    // Both buttons still held: first sample at edge 1, so each pulses once at 1+2+DB.
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk("postreset_pulse", {30'd0, button_pulse}, (c == 1 + 2 + DB) ? 32'h3 : 32'h0);
      chk("postreset_level", {30'd0, button_level}, (c >= 1 + 2 + DB) ? 32'h3 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
